// File: rtl/serial_subtractor_nbit.sv
// Multi-cycle add/subtract unit that works through the operands SLICE bits per clock.
// The LSB slice goes first. The borrow or carry from each slice feeds the next slice.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request; accepted only in IDLE or DONE
//   op    - 0 = A - B - Bin, 1 = A + B + Bin (captured with start)
//   A, B  - WIDTH-bit operands (captured with start)
//   Bin   - borrow-in / carry-in (captured with start)
//   busy  - high while slices are being processed
//   done  - one-cycle pulse; D/Bout/V are valid
//   D     - WIDTH-bit result
//   Bout  - borrow-out / carry-out
//   V     - two's-complement signed overflow
module serial_subtractor_nbit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    // Reject illegal parameter combinations at elaboration time.
    if (SLICE < 1 || WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("serial_subtractor_nbit: WIDTH must be >= 2 and divisible by SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             op_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] slice_d;
    logic             slice_c;
    logic [WIDTH-1:0] d_full;
    logic             v_c;
    int unsigned      slice_lo;
    logic             ab;
    logic             bb;
    logic             cb;

    // One SLICE-bit ripple slice.
    // The active slice's bits are merged into the partial result so the last slice can load D directly.
    always_comb begin
        slice_lo = 32'(cnt) * SLICE;
        slice_d  = '0;
        ab       = 1'b0;
        bb       = 1'b0;
        cb       = carry;
        for (int i = 0; i < int'(SLICE); i++) begin
            ab         = a_reg[slice_lo + 32'(i)];
            bb         = b_reg[slice_lo + 32'(i)];
            slice_d[i] = ab ^ bb ^ cb;
            if (op_reg) begin
                cb = (ab & bb) | (cb & (ab ^ bb));
            end else begin
                cb = (~ab & bb) | (~(ab ^ bb) & cb);
            end
        end
        slice_c = cb;
        d_full  = res_reg;
        d_full[slice_lo +: SLICE] = slice_d;
        if (op_reg) begin
            v_c = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (d_full[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
            v_c = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) & (d_full[WIDTH-1] != a_reg[WIDTH-1]);
        end
    end

    // Control FSM. Operands and outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
            V       <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            op_reg  <= 1'b0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        op_reg  <= op;
                        carry   <= Bin;
                        res_reg <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_reg <= d_full;
                    carry   <= slice_c;
                    if (cnt == CW'(N - 1)) begin
                        D     <= d_full;
                        Bout  <= slice_c;
                        V     <= v_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed bench with two instances: an 8-bit design processing 1 bit per clock,
// and a 16-bit design processing 4 bits per clock.
module tb_serial_subtractor_nbit;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, op8, bin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, bout8, v8;
    logic [7:0]  d8;

    logic        start16, op16, bin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, bout16, v16;
    logic [15:0] d16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_nbit #(.WIDTH(8), .SLICE(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .V(v8)
    );

    serial_subtractor_nbit #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .A(a16), .B(b16), .Bin(bin16),
        .busy(busy16), .done(done16), .D(d16), .Bout(bout16), .V(v16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one 8-bit operation and check its latency and results.
    task automatic run8(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb, input logic ev);
        int busy_cyc = 0;
        int cyc = 0;
        @(negedge clk);
        start8 = 1'b1; op8 = o; a8 = a; b8 = b; bin8 = bi;
        @(negedge clk);
        start8 = 1'b0;
        while (!done8 && cyc < 50) begin
            if (busy8) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 32'(done8), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd8);
        check({tag, "_busy_with_done"}, 32'(busy8), 32'd0);
        check({tag, "_D"}, 32'(d8), 32'(ed));
        check({tag, "_Bout"}, 32'(bout8), 32'(eb));
        check({tag, "_V"}, 32'(v8), 32'(ev));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
    endtask

    // Issue one 16-bit operation. With disturb set, change the inputs and pulse
    // start mid-run; the result must not change.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic disturb, input logic [15:0] prev_d, input logic [15:0] ed);
        int busy_cyc = 0;
        int cyc = 0;
        @(negedge clk);
        start16 = 1'b1; op16 = 1'b0; a16 = a; b16 = b; bin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        while (!done16 && cyc < 50) begin
            if (busy16) busy_cyc++;
            if (disturb && cyc == 1) begin
                check({tag, "_D_hold"}, 32'(d16), 32'(prev_d));
                a16 = 16'hFFFF; b16 = 16'h0001; op16 = 1'b1; bin16 = 1'b1; start16 = 1'b1;
            end
            if (cyc == 2) start16 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start16 = 1'b0;
        check({tag, "_done_seen"}, 32'(done16), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd4);
        check({tag, "_D"}, 32'(d16), 32'(ed));
        check({tag, "_Bout"}, 32'(bout16), 32'd0);
        check({tag, "_V"}, 32'(v16), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done16), 32'd0);
        check({tag, "_no_requeue"}, 32'(busy16), 32'd0);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        rst = 1'b1;
        start8 = 0; op8 = 0; bin8 = 0; a8 = '0; b8 = '0;
        start16 = 0; op16 = 0; bin16 = 0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_D", 32'(d8), 32'd0);
        check("rst_Bout", 32'(bout8), 32'd0);
        check("rst_V", 32'(v8), 32'd0);
        check("rst_D16", 32'(d16), 32'd0);

        // Basic subtract, borrow cases and overflow cases
        run8("sub_7_2",   1'b0, 8'd7,   8'd2,   1'b0, 8'h05, 1'b0, 1'b0);
        run8("sub_1_3",   1'b0, 8'd1,   8'd3,   1'b0, 8'hFE, 1'b1, 1'b0);
        run8("sub_0_1",   1'b0, 8'd0,   8'd1,   1'b0, 8'hFF, 1'b1, 1'b0);
        run8("sub_4_4_b", 1'b0, 8'd4,   8'd4,   1'b1, 8'hFF, 1'b1, 1'b0);
        run8("sub_4_4",   1'b0, 8'd4,   8'd4,   1'b0, 8'h00, 1'b0, 1'b0);
        run8("sub_ovf",   1'b0, 8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1);
        run8("add_ovf",   1'b1, 8'h7F,  8'h01,  1'b0, 8'h80, 1'b0, 1'b1);
        run8("add_wrap",  1'b1, 8'hFF,  8'h01,  1'b0, 8'h00, 1'b1, 1'b0);
        run8("add_cin",   1'b1, 8'h0F,  8'h10,  1'b1, 8'h20, 1'b0, 1'b0);

        // 16-bit, 4-bit slices; then ignore start and input changes during RUN
        run16("w16", 16'h1234, 16'h0235, 1'b0, 16'h0000, 16'h0FFF);
        run16("w16_dist", 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 16'h0FFF);

        // Back-to-back: start held across the done cycle
        @(negedge clk);
        start8 = 1'b1; op8 = 1'b0; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!done8 && cyc < 50) begin @(negedge clk); cyc++; end
        check("b2b_first_done", 32'(done8), 32'd1);
        check("b2b_first_D", 32'(d8), 32'h0F);
        op8 = 1'b1; a8 = 8'h20; b8 = 8'h03;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_accepted", 32'(busy8), 32'd1);
        cyc = 1;
        while (!done8 && cyc < 50) begin @(negedge clk); cyc++; end
        check("b2b_spacing", 32'(cyc), 32'd9);
        check("b2b_second_D", 32'(d8), 32'h23);
        check("b2b_second_Bout", 32'(bout8), 32'd0);

        // Reset 3 cycles into RUN aborts the operation
        @(negedge clk);
        start8 = 1'b1; op8 = 1'b0; a8 = 8'h50; b8 = 8'h10; bin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_D", 32'(d8), 32'd0);
        check("abort_Bout", 32'(bout8), 32'd0);
        check("abort_V", 32'(v8), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // start together with rst is not accepted
        start8 = 1'b1; rst = 1'b1; a8 = 8'h33; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy8), 32'd0);

        run8("after_abort", 1'b0, 8'd8, 8'd2, 1'b0, 8'h06, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
- Parametrised, multi-cycle successor to the combinational 4-bit ripple-borrow subtractor.
- Processes WIDTH-bit operands SLICE bits per clock through one SLICE-bit borrow/carry slice, with a start/done handshake.
- Adds an add/subtract mode and a signed-overflow flag.
- Used where area matters more than latency, e.g. datapath ALUs in lab designs.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- SLICE, 1, bits processed per clock; must divide WIDTH exactly. Violating either is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is idle or in its done cycle
- op  input  1  0 = subtract (A − B − Bin), 1 = add (A + B + Bin); captured with start
- A  input  WIDTH  minuend/addend; captured with start
- B  input  WIDTH  subtrahend/addend; captured with start
- Bin  input  1  borrow-in (sub) or carry-in (add); captured with start
- busy  output  1  high while a slice operation is in progress
- done  output  1  one-cycle pulse; results valid
- D  output  WIDTH  result
- Bout  output  1  borrow-out (sub) or carry-out (add)
- V  output  1  two's-complement signed overflow

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst is sampled on the rising clk edge and has priority over all other inputs.
- Reset values: state = IDLE, busy = 0, done = 0, D = 0, Bout = 0, V = 0, and all internal operand and slice registers cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start = 1 → latch A, B, Bin and op; clear the slice counter; go to RUN.
  - IDLE, start = 0 → stay in IDLE.
  - RUN, counter < N−1, where N = WIDTH/SLICE → process slice k (bits k·SLICE … k·SLICE+SLICE−1, LSB slice first); feed the slice borrow/carry to the next slice; increment the counter.
  - RUN, counter = N−1 → process the last slice; load D, Bout and V; go to DONE.
  - DONE → done = 1 for exactly this cycle.
  - DONE, start = 1 → accept a new operation as in IDLE (back-to-back issue, no bubble).
  - DONE, start = 0 → go to IDLE.
- Latency:
  - If start is sampled at edge e0, slices are processed at edges e1 … eN.
  - done is high in the cycle after eN.
  - busy is high from after e0 until eN; busy and done are never both high.
- Throughput: one operation per N+1 cycles.
- Output hold: D, Bout and V change only on the transition into DONE. They hold their previous values during RUN and keep the last result in IDLE until the next completion or reset.
- Input capture: inputs are captured only at acceptance. Changes to A, B, Bin or op during RUN have no effect.
- start during RUN is ignored; it is not queued.
- Subtract arithmetic (op = 0):
  - D = (A − B − Bin) mod 2^WIDTH.
  - Bout = 1 iff unsigned A < B + Bin.
  - Per-bit rule: diff = a ^ b ^ bi; bo = (~a & b) | (~(a ^ b) & bi).
- Add arithmetic (op = 1):
  - D = (A + B + Bin) mod 2^WIDTH.
  - Bout = carry out of the MSB.
- Signed overflow V:
  - Subtract: V = (A[MSB] ≠ B[MSB]) & (D[MSB] ≠ A[MSB]).
  - Add: V = (A[MSB] = B[MSB]) & (D[MSB] ≠ A[MSB]).
- Wrap-around: results are always modulo 2^WIDTH. No saturation.
- Reset mid-operation: the operation is aborted and everything returns to reset values. No done pulse is produced for the aborted operation.
- Simultaneous start and rst: rst wins and the operation is not accepted.

Test Plan:
- 1. WIDTH = 8, SLICE = 1, op = 0, Bin = 0, A = 7, B = 2, start pulsed → busy for 8 cycles, then done = 1 for 1 cycle with D = 0x05, Bout = 0, V = 0.
- 2. Subtract borrow cases, WIDTH = 8, SLICE = 1:
  - A = 1, B = 3 → D = 0xFE, Bout = 1.
  - A = 0, B = 1 → D = 0xFF, Bout = 1.
  - A = 4, B = 4, Bin = 1 → D = 0xFF, Bout = 1.
  - A = 4, B = 4, Bin = 0 → D = 0x00, Bout = 0.
- 3. Overflow cases, WIDTH = 8, SLICE = 1:
  - Subtract A = 0x80, B = 0x01 → D = 0x7F, Bout = 0, V = 1.
  - Add (op = 1) A = 0x7F, B = 0x01 → D = 0x80, Bout = 0, V = 1.
  - Add A = 0xFF, B = 0x01 → D = 0x00, Bout = 1, V = 0.
- 4. WIDTH = 16, SLICE = 4, A = 0x1234, B = 0x0235, op = 0 → done 4 cycles after busy rises, D = 0x0FFF, Bout = 0. Then change A/B and pulse start during busy → ignored; result unchanged.
- 5. Back-to-back issue: start held high across done → the next operation is accepted in the DONE cycle. Both results are correct and done pulses are spaced N+1 cycles apart.
- 6. rst asserted 3 cycles into RUN → next cycle busy = 0, D = 0, Bout = 0, V = 0, no done pulse. A subsequent A = 8, B = 2 operation → D = 0x06, Bout = 0.
